dbg_loader: RTL and testbench
=============================

Name: dbg_loader

Overview:
- Program loader directly upstream of cpuCore's debug instruction-write port (dbg_wr_en / dbg_addr / dbg_instr).
- Consumes a framed byte stream from a UART-RX-style source and assembles little-endian 32-bit words.
- Writes each word into instruction memory through one-cycle dbg_wr_en pulses.
- Holds the core in reset (core_rst) until a frame with a valid checksum completes.

Parameters:
- XLEN, 32, data/address width of the debug port.
- HEADER, 8'hA5, frame start byte.
- CNT_W, 16, width of the word-count field.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid; byte is accepted when in_valid && in_ready.
- in_ready  out  1  loader can accept a byte.
- dbg_wr_en  out  1  one-cycle write strobe to cpuCore.
- dbg_addr  out  XLEN  instruction byte address, word-aligned.
- dbg_instr  out  XLEN  instruction word.
- core_rst  out  1  active-high reset to cpuCore.
- busy  out  1  frame in progress (any state except IDLE and RUN).
- err  out  1  sticky checksum-error flag.

Behaviour:
- Frame format, all fields little-endian:
  - HEADER
  - ADDR: 4 bytes
  - COUNT: 2 bytes, N words
  - DATA: N×4 bytes
  - CSUM: 1 byte, XOR of every byte after HEADER
- Reset values while rst=0: dbg_wr_en=0, dbg_addr=0, dbg_instr=0, core_rst=1, busy=0, err=0, in_ready=0, state=IDLE.
- States and transitions:
  - IDLE: in_ready=1. Byte==HEADER → ADDR and clear the running XOR. Any other byte is dropped.
  - ADDR: collect 4 bytes. On the 4th byte, latch start address with bits [1:0] forced to 0 → COUNT.
  - COUNT: collect 2 bytes. N==0 → CSUM; otherwise → DATA.
  - DATA: collect 4 bytes into the word assembler. On the 4th byte → WRITE.
  - WRITE: exactly one cycle. in_ready=0, dbg_wr_en=1, dbg_addr=current address, dbg_instr=assembled word. Then address += 4 (mod 2^XLEN) and remaining N -= 1. Remaining 0 → CSUM; otherwise → DATA.
  - CSUM: one byte. Byte == running XOR → RUN. Mismatch → set err=1 and go to IDLE.
  - RUN: core_rst=0, in_ready=1. Byte==HEADER → core_rst=1 on the next cycle, → ADDR. Other bytes are dropped.
- Latency:
  - Last byte of a word accepted at edge t → dbg_wr_en high for cycle t+1 only.
  - dbg_addr and dbg_instr stay stable from that cycle until the next write.
- core_rst:
  - Asserted in every state except RUN.
  - Deasserts the cycle after a matching CSUM byte is accepted.
  - A checksum failure leaves the core in reset.
- err:
  - Set on checksum mismatch.
  - Cleared only when a subsequent CSUM matches, or by rst.
  - Writes already issued before a failed checksum are not undone.
- Running XOR covers ADDR, COUNT and DATA bytes; it excludes HEADER and CSUM.
- A HEADER value seen inside ADDR/COUNT/DATA is payload, not a resync.
- in_valid low stalls any state indefinitely with no timeout; state and outputs hold.
- N = 2^CNT_W−1 must complete without counter overflow.
- rst asserted mid-frame: immediate return to the reset values above. A partial frame is discarded; writes already issued remain in memory.

Decomposition:
- Package dbg_loader_pkg:
  - state enum {IDLE, ADDR, COUNT, DATA, WRITE, CSUM, RUN}
  - HEADER default
  - byte-index width localparam
- Sub-module word_assembler:
  - 2-bit byte index plus XLEN shift register; loads byte k into bits [8k+7:8k].
  - Signals word-complete on the 4th byte and clears on restart.
- The FSM, address/count counters and XOR stay in dbg_loader.

Test Plan:
- Good two-word frame A5, 04 00 00 00, 02 00, 13 81 50 E7, 93 01 91 55, 75 → two writes: (addr 0x4, 0xE7508113) then (addr 0x8, 0x55910193), one-cycle pulses; core_rst falls the cycle after 0x75 is accepted; err=0.
- Same frame with CSUM=0x76 → same two writes; err=1; core_rst stays 1; state IDLE. Resending the correct frame → err=0 and core_rst=0.
- N=0 frame A5, 10 00 00 00, 00 00, 10 → no dbg_wr_en pulse; core_rst released.
- Unaligned address 0x07 and wrap test address 0xFFFFFFFC with N=2 → first write addr 0x4 for the 0x07 frame; for the wrap frame, writes at 0xFFFFFFFC then 0x00000000.
- Garbage bytes 00 FF 12 before the header, plus random in_valid gaps inside the frame → garbage ignored, identical write sequence; in_ready=0 only in WRITE cycles.
- rst pulsed low after the 2nd data byte, then reload in RUN with a new HEADER → all outputs reset immediately; new HEADER re-asserts core_rst next cycle and a fresh load completes normally.

Source files
------------

// File: rtl/dbg_loader_pkg.sv
// Shared types and defaults for the debug program loader.
// Imported by the loader FSM and its word assembler.
package dbg_loader_pkg;

    localparam int         XLEN_DEF   = 32;
    localparam logic [7:0] HEADER_DEF = 8'hA5;
    localparam int         CNT_W_DEF  = 16;
    localparam int         IDX_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        COUNT,
        DATA,
        WRITE,
        CSUM,
        RUN
    } state_t;

endpackage

// File: rtl/dbg_loader_word_assembler.sv
// Little-endian byte-to-word assembler.
// Byte k of a word lands in bits [8k+7:8k].
module word_assembler
    import dbg_loader_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [7:0]       byte_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [XLEN-1:0]  word_next_o,
    output logic             done_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]  word_q, word_d;

    // word_next_o already holds the incoming byte so the
    // caller can latch a complete word on the 4th byte.
    always_comb begin
        word_next_o = word_q;
        word_next_o[8*idx_q +: 8] = byte_i;
        idx_d  = idx_q;
        word_d = word_q;
        if (clr_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (load_i) begin
            idx_d  = idx_q + IDX_W'(1);
            word_d = word_next_o;
        end
    end

    assign done_o = load_i && (idx_q == '1);
    assign idx_o  = idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/dbg_loader.sv
// Framed byte-stream program loader driving the core's
// debug instruction-write port; holds the core in reset.
module dbg_loader
    import dbg_loader_pkg::*;
#(
    parameter int         XLEN   = XLEN_DEF,
    parameter logic [7:0] HEADER = HEADER_DEF,
    parameter int         CNT_W  = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            dbg_wr_en,
    output logic [XLEN-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_instr,
    output logic            core_rst,
    output logic            busy,
    output logic            err
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
    logic [XLEN-1:0]   daddr_q, daddr_d;
    logic [XLEN-1:0]   dinstr_q, dinstr_d;
    logic              crst_q, crst_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;

    logic              acc;
    logic              asm_clr, asm_load, asm_done;
    logic [IDX_W-1:0]  asm_idx;
    logic [XLEN-1:0]   asm_next;

    word_assembler #(.XLEN(XLEN)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (asm_clr),
        .load_i     (asm_load),
        .byte_i     (in_data),
        .idx_o      (asm_idx),
        .word_next_o(asm_next),
        .done_o     (asm_done)
    );

    assign acc = in_valid && rdy_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        csum_d   = csum_q;
        err_d    = err_q;
        wr_d     = 1'b0;
        daddr_d  = daddr_q;
        dinstr_d = dinstr_q;
        asm_clr  = 1'b0;
        asm_load = 1'b0;
        unique case (state_q)
            IDLE, RUN: begin
                if (acc && in_data == HEADER) begin
                    state_d = ADDR;
                    csum_d  = '0;
                    asm_clr = 1'b1;
                end
            end
            ADDR: begin
                if (acc) begin
                    csum_d   = csum_q ^ in_data;
                    asm_load = 1'b1;
                    if (asm_done) begin
                        addr_d  = {asm_next[XLEN-1:2], 2'b00};
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                if (acc) begin
                    csum_d   = csum_q ^ in_data;
                    asm_load = 1'b1;
                    if (asm_idx == IDX_W'(1)) begin
                        asm_clr = 1'b1;
                        rem_d   = asm_next[CNT_W-1:0];
                        state_d = (asm_next[CNT_W-1:0] == '0)
                                ? CSUM : DATA;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    csum_d   = csum_q ^ in_data;
                    asm_load = 1'b1;
                    if (asm_done) begin
                        wr_d     = 1'b1;
                        daddr_d  = addr_q;
                        dinstr_d = asm_next;
                        state_d  = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d  = addr_q + XLEN'(4);
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? CSUM : DATA;
            end
            CSUM: begin
                if (acc) begin
                    if (in_data == csum_q) begin
                        err_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        crst_d = (state_d != RUN);
        busy_d = (state_d != IDLE) && (state_d != RUN);
        rdy_d  = (state_d != WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            csum_q   <= '0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            daddr_q  <= '0;
            dinstr_q <= '0;
            crst_q   <= 1'b1;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            csum_q   <= csum_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
            daddr_q  <= daddr_d;
            dinstr_q <= dinstr_d;
            crst_q   <= crst_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign dbg_wr_en = wr_q;
    assign dbg_addr  = daddr_q;
    assign dbg_instr = dinstr_q;
    assign core_rst  = crst_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dbg_loader.sv
// Randomized frame-level bench for dbg_loader.
// Expected writes are derived from the frame contents.
module tb_dbg_loader;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        dbg_wr_en;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_instr;
    logic        core_rst;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    int          pulses = 0;
    int          width_err = 0;
    int          rdy_err = 0;
    int          stab_err = 0;
    bit          mon_en = 1'b0;
    logic        prev_wr = 1'b0;
    logic [31:0] la = '0;
    logic [31:0] li = '0;

    logic [31:0] fw[$];

    dbg_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dbg_wr_en(dbg_wr_en),
        .dbg_addr (dbg_addr),
        .dbg_instr(dbg_instr),
        .core_rst (core_rst),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Pulse width, in_ready only low while writing, outputs held between writes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dbg_wr_en) begin
                pulses++;
                if (prev_wr) width_err++;
            end else if (dbg_addr !== la || dbg_instr !== li) begin
                stab_err++;
            end
            if (in_ready !== !dbg_wr_en) rdy_err++;
            prev_wr = dbg_wr_en;
            la = dbg_addr;
            li = dbg_instr;
        end
    end

    task automatic start_mon();
        @(posedge clk);
        @(negedge clk);
        prev_wr = dbg_wr_en;
        la = dbg_addr;
        li = dbg_instr;
        mon_en = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        int t;
        n = gaps ? int'($urandom_range(0, 3)) : 0;
        repeat (n + 1) @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%b wanted 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic send_frame(input logic [31:0] a, input bit bad,
                              input bit gaps);
        logic [7:0]  b[$];
        logic [7:0]  x;
        logic [15:0] cnt;
        logic [31:0] ea;
        int          base;
        b = {};
        for (int i = 0; i < 4; i++) b.push_back(a[8*i +: 8]);
        cnt = 16'(fw.size());
        b.push_back(cnt[7:0]);
        b.push_back(cnt[15:8]);
        foreach (fw[w])
            for (int k = 0; k < 4; k++) b.push_back(fw[w][8*k +: 8]);
        x = 8'h00;
        foreach (b[i]) x ^= b[i];
        base = pulses;
        send_byte(HDR, gaps);
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL after_header: core_rst=%b busy=%b wanted 1 1",
                     core_rst, busy);
        end
        for (int i = 0; i < 6; i++) send_byte(b[i], gaps);
        foreach (fw[w]) begin
            for (int k = 0; k < 4; k++) send_byte(b[6 + 4*w + k], gaps);
            ea = (a & 32'hFFFF_FFFC) + 32'(4 * w);
            @(negedge clk);
            checks++;
            if (dbg_wr_en !== 1'b1 || dbg_addr !== ea
                || dbg_instr !== fw[w]) begin
                errors++;
                $display("FAIL write%0d: en=%b addr=%h instr=%h wanted 1 %h %h",
                         w, dbg_wr_en, dbg_addr, dbg_instr, ea, fw[w]);
            end
        end
        send_byte(bad ? (x ^ 8'h03) : x, gaps);
        @(negedge clk);
        checks++;
        if (core_rst !== bad || err !== bad || busy !== 1'b0) begin
            errors++;
            $display("FAIL csum_end: core_rst=%b err=%b busy=%b wanted %b %b 0",
                     core_rst, err, busy, bad, bad);
        end
        checks++;
        if (pulses - base !== fw.size()) begin
            errors++;
            $display("FAIL pulse_count: got %0d wanted %0d",
                     pulses - base, fw.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dbg_wr_en !== 1'b0 || dbg_addr !== 32'h0 || dbg_instr !== 32'h0
            || core_rst !== 1'b1 || busy !== 1'b0 || err !== 1'b0
            || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset: wr=%b a=%h i=%h crst=%b busy=%b err=%b rdy=%b",
                     dbg_wr_en, dbg_addr, dbg_instr, core_rst, busy, err,
                     in_ready);
        end
        rst = 1'b1;
        start_mon();
    endtask

    task automatic test_good_frame();
        fw = {32'hE750_8113, 32'h5591_0193};
        send_frame(32'h0000_0004, 1'b0, 1'b0);
    endtask

    task automatic test_bad_csum();
        fw = {32'hE750_8113, 32'h5591_0193};
        send_frame(32'h0000_0004, 1'b1, 1'b0);
        send_frame(32'h0000_0004, 1'b0, 1'b0);
    endtask

    task automatic test_zero_count();
        fw = {};
        send_frame(32'h0000_0010, 1'b0, 1'b0);
    endtask

    task automatic test_align_wrap();
        fw = {32'(($urandom))};
        send_frame(32'h0000_0007, 1'b0, 1'b0);
        fw = {32'h1234_5678, 32'(($urandom))};
        send_frame(32'hFFFF_FFFC, 1'b0, 1'b0);
    endtask

    task automatic test_garbage_gaps();
        logic [7:0] g[3];
        g = '{8'h00, 8'hFF, 8'h12};
        foreach (g[i]) begin
            send_byte(g[i], 1'b1);
            @(negedge clk);
            checks++;
            if (core_rst !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL garbage%0d: core_rst=%b busy=%b wanted 0 0",
                         i, core_rst, busy);
            end
        end
        fw = {32'hA5A5_A5A5, 32'(($urandom)), 32'h00A5_0000};
        send_frame(32'h0000_A5A4, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] p[$];
        p = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22};
        send_byte(HDR, 1'b0);
        foreach (p[i]) send_byte(p[i], 1'b0);
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: core_rst=%b busy=%b wanted 1 1",
                     core_rst, busy);
        end
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (dbg_wr_en !== 1'b0 || dbg_addr !== 32'h0 || dbg_instr !== 32'h0
            || core_rst !== 1'b1 || busy !== 1'b0 || err !== 1'b0
            || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: wr=%b a=%h i=%h crst=%b busy=%b rdy=%b",
                     dbg_wr_en, dbg_addr, dbg_instr, core_rst, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        start_mon();
        fw = {32'(($urandom)), 32'(($urandom))};
        send_frame(32'h0000_0100, 1'b0, 1'b0);
        fw = {32'(($urandom))};
        send_frame(32'h0000_0200, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 6; f++) begin
            fw = {};
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) fw.push_back(32'($urandom));
            send_frame(32'($urandom), bit'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    task automatic test_monitor();
        checks++;
        if (width_err !== 0 || rdy_err !== 0 || stab_err !== 0) begin
            errors++;
            $display("FAIL monitor: width=%0d rdy=%0d stable=%0d wanted 0 0 0",
                     width_err, rdy_err, stab_err);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_zero_count();
        test_align_wrap();
        test_garbage_gaps();
        test_reset_midframe();
        test_random();
        test_monitor();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
